// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the parametrised integer register file.
package regfile_pkg;

  // Sequencer states: CLEAR zeroes the array entry by entry, RUN is normal operation.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 32;
  localparam int RF_NRD   = 2;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port of the register file.
// The port returns zero while the file is not ready.
// It also returns zero for the hardwired zero entry.
// When REGFILE_BYPASS_EN is defined, a write that fires in the same cycle to
// the same address is forwarded to the output.
module regfile_rdport #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                  ready,
  input  logic [AW-1:0]         raddr,
  input  logic [DEPTH*DW-1:0]   mem_flat,
  input  logic                  wr_fire,
  input  logic [AW-1:0]         waddr,
  input  logic [DW-1:0]         wdata,
  output logic [DW-1:0]         rdata
);

`ifndef REGFILE_BYPASS_EN
  // Forwarding inputs are only consumed by the bypass build.
  logic unused_bypass;
  assign unused_bypass = ^{wr_fire, waddr, wdata};
`endif

  // Read mux with ready gating, zero-register masking and optional forwarding.
  always_comb begin
    rdata = {DW{1'b0}};
    if (!ready) begin
      rdata = {DW{1'b0}};
    end else if (ZERO_REG && (raddr == {AW{1'b0}})) begin
      rdata = {DW{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (wr_fire && (waddr == raddr)) begin
      rdata = wdata;
`endif
    end else begin
      rdata = mem_flat[int'(raddr)*DW +: DW];
    end
  end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file with hardwired zero entry and a clear sequencer.
// The storage array has no reset. After reset, or on clear_req, the sequencer
// writes zero to every entry, one per cycle, before the file reports ready.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writes to the read ports.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DW       = RF_DW,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NRD      = RF_NRD,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_req,
  output logic                ready,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [DW-1:0]       wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*DW-1:0]   rdata
);

  // Counter is one bit wider than the address so the terminal compare never wraps.
  localparam logic [AW:0] CLR_LAST = DEPTH[AW:0] - {{AW{1'b0}}, 1'b1};

  rf_state_e         state_q, state_d;
  logic [AW:0]       clr_cnt_q, clr_cnt_d;
  logic              ready_q, ready_d;

  logic              wr_en;
  logic              wr_fire;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;

  logic [DW-1:0]     mem_q [DEPTH];
  logic [DEPTH*DW-1:0] mem_flat;

  // State register: the sequencer restarts from entry 0 whenever reset is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= {(AW+1){1'b0}};
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state logic: walk the clear counter, and let clear_req restart the walk.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        if (clear_req) begin
          clr_cnt_d = {(AW+1){1'b0}};
        end else if (clr_cnt_q == CLR_LAST) begin
          state_d   = RUN;
          clr_cnt_d = clr_cnt_q + {{AW{1'b0}}, 1'b1};
        end else begin
          clr_cnt_d = clr_cnt_q + {{AW{1'b0}}, 1'b1};
        end
      end
      RUN: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_cnt_d = {(AW+1){1'b0}};
        end else begin
          state_d   = RUN;
          clr_cnt_d = clr_cnt_q;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = {(AW+1){1'b0}};
      end
    endcase
  end

  // Output logic: pick the write source (the clear walk or the writeback port) and compute ready.
  always_comb begin
    ready_d = (state_d == RUN);
    wr_en   = 1'b0;
    wr_fire = 1'b0;
    wr_addr = {AW{1'b0}};
    wr_data = {DW{1'b0}};
    case (state_q)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt_q[AW-1:0];
        wr_data = {DW{1'b0}};
      end
      RUN: begin
        // A clear request takes priority over a write in the same cycle.
        if (we && !clear_req && !(ZERO_REG && (waddr == {AW{1'b0}}))) begin
          wr_en   = 1'b1;
          wr_fire = 1'b1;
          wr_addr = waddr;
          wr_data = wdata;
        end else begin
          wr_en   = 1'b0;
          wr_fire = 1'b0;
          wr_addr = {AW{1'b0}};
          wr_data = {DW{1'b0}};
        end
      end
      default: begin
        wr_en   = 1'b0;
        wr_fire = 1'b0;
        wr_addr = {AW{1'b0}};
        wr_data = {DW{1'b0}};
      end
    endcase
  end

  // Storage array write port; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign ready = ready_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign mem_flat[g*DW +: DW] = mem_q[g];
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_rdport #(
      .DW       (DW),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .ready    (ready_q),
      .raddr    (raddr[i*AW +: AW]),
      .mem_flat (mem_flat),
      .wr_fire  (wr_fire),
      .waddr    (waddr),
      .wdata    (wdata),
      .rdata    (rdata[i*DW +: DW])
    );
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default configuration plus a small sweep instance.
module tb_regfile_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: DW=32, DEPTH=32, NRD=2, ZERO_REG=1.
  logic        rst, clear_req, we, ready;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;

  // Sweep instance: DW=16, DEPTH=8, NRD=3, ZERO_REG=0.
  logic        rst2, clear_req2, we2, ready2;
  logic [2:0]  waddr2;
  logic [15:0] wdata2;
  logic [8:0]  raddr2;
  logic [47:0] rdata2;

  int checks = 0;
  int errors = 0;

  logic [4:0] cleared_addr [5];

  regfile_param u_dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .ready(ready),
    .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata)
  );

  regfile_param #(.DW(16), .DEPTH(8), .NRD(3), .ZERO_REG(1'b0)) u_dut2 (
    .clk(clk), .rst(rst2), .clear_req(clear_req2), .ready(ready2),
    .we(we2), .waddr(waddr2), .wdata(wdata2), .raddr(raddr2), .rdata(rdata2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic wr2(input logic [2:0] a, input logic [15:0] d);
    we2 = 1'b1; waddr2 = a; wdata2 = d;
    step();
    we2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear_req = 1'b0; we = 1'b0; waddr = 5'd0; wdata = 32'd0; raddr = 10'd0;
    rst2 = 1'b1; clear_req2 = 1'b0; we2 = 1'b0; waddr2 = 3'd0; wdata2 = 16'd0; raddr2 = 9'd0;
    cleared_addr = '{5'd3, 5'd5, 5'd9, 5'd31, 5'd7};

    step(); step();
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_rdata", rdata, 64'd0);

    // Reset release then clear walk, with write attempts that must be ignored.
    rst = 1'b0;
    raddr = {5'd31, 5'd5};
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    for (int k = 1; k <= 32; k++) begin
      step();
      check("clr_ready", {63'd0, ready}, (k == 32) ? 64'd1 : 64'd0);
      if (k < 32) begin
        check("clr_rdata", rdata, 64'd0);
        waddr = 5'(k);
      end else begin
        we = 1'b0;
      end
    end

    // All entries read zero after the clear.
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(31 - a), 5'(a)};
      #1;
      check("idle_rd0", {32'd0, rdata[31:0]}, 64'd0);
      check("idle_rd1", {32'd0, rdata[63:32]}, 64'd0);
    end

    // Write then read on both ports.
    wr(5'd5, 32'hDEAD_BEEF);
    wr(5'd9, 32'h0BAD_F00D);
    wr(5'd31, 32'h3131_3131);
    wr(5'd7, 32'h1111_1111);
    raddr = {5'd5, 5'd5}; #1;
    check("wr5_rd0", {32'd0, rdata[31:0]}, 64'hDEAD_BEEF);
    check("wr5_rd1", {32'd0, rdata[63:32]}, 64'hDEAD_BEEF);
    raddr = {5'd31, 5'd6}; #1;
    check("rd6_zero", {32'd0, rdata[31:0]}, 64'd0);
    check("rd31", {32'd0, rdata[63:32]}, 64'h3131_3131);

    // Hardwired zero entry.
    wr(5'd0, 32'h1234_5678);
    raddr = {5'd0, 5'd0}; #1;
    check("zero_rd0", {32'd0, rdata[31:0]}, 64'd0);
    check("zero_rd1", {32'd0, rdata[63:32]}, 64'd0);

    // Same-cycle write/read of entry 7.
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5; raddr = {5'd7, 5'd9}; #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_same", {32'd0, rdata[63:32]}, 64'hA5A5_A5A5);
`else
    check("byp_same", {32'd0, rdata[63:32]}, 64'h1111_1111);
`endif
    check("byp_other", {32'd0, rdata[31:0]}, 64'h0BAD_F00D);
    step(); we = 1'b0; #1;
    check("byp_after", {32'd0, rdata[63:32]}, 64'hA5A5_A5A5);

    // Write to the zero entry is never forwarded.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr = {5'd0, 5'd7}; #1;
    check("byp_zero", {32'd0, rdata[63:32]}, 64'd0);
    step(); we = 1'b0;

    // Clear request with a simultaneous write to entry 3.
    we = 1'b1; waddr = 5'd3; wdata = 32'h3333_3333; clear_req = 1'b1; raddr = {5'd3, 5'd5};
    step();
    we = 1'b0; clear_req = 1'b0;
    check("creq_ready0", {63'd0, ready}, 64'd0);
    check("creq_rdata0", rdata, 64'd0);
    for (int k = 1; k <= 32; k++) begin
      step();
      check("creq_ready", {63'd0, ready}, (k == 32) ? 64'd1 : 64'd0);
    end
    for (int j = 0; j < 5; j++) begin
      raddr = {cleared_addr[j], cleared_addr[j]}; #1;
      check("creq_cleared", rdata, 64'd0);
    end

    // A clear request during a clear restarts the walk.
    clear_req = 1'b1; step(); clear_req = 1'b0;
    for (int k = 1; k <= 5; k++) step();
    clear_req = 1'b1; step(); clear_req = 1'b0;
    check("restart_ready0", {63'd0, ready}, 64'd0);
    for (int k = 1; k <= 32; k++) begin
      step();
      check("restart_ready", {63'd0, ready}, (k == 32) ? 64'd1 : 64'd0);
    end

    // Asynchronous reset in RUN, then again mid-clear.
    wr(5'd12, 32'hCAFE_F00D);
    raddr = {5'd12, 5'd12}; #1;
    check("pre_rst_rd", {32'd0, rdata[31:0]}, 64'hCAFE_F00D);
    rst = 1'b1; #1;
    check("async_ready", {63'd0, ready}, 64'd0);
    check("async_rdata", rdata, 64'd0);
    step(); rst = 1'b0;
    for (int k = 1; k <= 10; k++) step();
    check("mid_ready", {63'd0, ready}, 64'd0);
    #2 rst = 1'b1; #1;
    check("mid_rst_ready", {63'd0, ready}, 64'd0);
    step(); rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      step();
      check("rerst_ready", {63'd0, ready}, (k == 32) ? 64'd1 : 64'd0);
    end
    raddr = {5'd12, 5'd12}; #1;
    check("rerst_cleared", rdata, 64'd0);

    // Sweep instance: 8-entry clear, writable entry 0, three independent ports.
    step(); rst2 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("sw_clr_ready", {63'd0, ready2}, (k == 8) ? 64'd1 : 64'd0);
    end
    raddr2 = {3'd7, 3'd3, 3'd0}; #1;
    check("sw_idle", {16'd0, rdata2}, 64'd0);
    wr2(3'd0, 16'hBEEF);
    wr2(3'd3, 16'h1234);
    wr2(3'd7, 16'h7777);
    wr2(3'd5, 16'h5555);
    raddr2 = {3'd7, 3'd3, 3'd0}; #1;
    check("sw_p0_a0", {48'd0, rdata2[15:0]}, 64'hBEEF);
    check("sw_p1_a3", {48'd0, rdata2[31:16]}, 64'h1234);
    check("sw_p2_a7", {48'd0, rdata2[47:32]}, 64'h7777);
    raddr2 = {3'd5, 3'd0, 3'd7}; #1;
    check("sw_p0_a7", {48'd0, rdata2[15:0]}, 64'h7777);
    check("sw_p1_a0", {48'd0, rdata2[31:16]}, 64'hBEEF);
    check("sw_p2_a5", {48'd0, rdata2[47:32]}, 64'h5555);
    raddr2 = {3'd3, 3'd3, 3'd3}; #1;
    check("sw_same", {16'd0, rdata2}, 64'h1234_1234_1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
